// File: rtl/iuq_rn_ptr_track_pkg.sv
// Shared definitions for the rename ring pointer tracker.
// Pointers are big-endian vectors [0:SIZE-1]: bit 0 is the wrap bit, the rest is the index.
package iuq_rn_ptr_track_pkg;

    localparam int unsigned WRAP_POS = 0;
    localparam int unsigned IDX_LSB  = 1;

    localparam int DEFAULT_SIZE  = 7;
    localparam int DEFAULT_DEPTH = 40;

    // Per-cycle step counts are 2 bits wide; 3 is not a legal step.
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_ONE     = 2'd1,
        STEP_TWO     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_cnt_t;

endpackage

// File: rtl/iuq_rn_map_dec.sv
// Wrapping pointer decrement by 0..2 on a ring of DEPTH entries.
module iuq_rn_map_dec
    import iuq_rn_ptr_track_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic [0:1]      dec,
    input  logic [0:SIZE-1] i,
    output logic [0:SIZE-1] o
);

    localparam int IW = SIZE - 1;
    localparam logic [SIZE-1:0] DEPTH_S = DEPTH[SIZE-1:0];

    logic [IW-1:0]   idx;
    logic [SIZE-1:0] wrapped;

    // Step back within the ring, toggling the wrap bit when crossing index 0.
    always_comb begin
        idx     = i[IDX_LSB:SIZE-1];
        wrapped = {1'b0, idx} + DEPTH_S - SIZE'(dec);
        if (idx >= IW'(dec)) begin
            o = {i[WRAP_POS], idx - IW'(dec)};
        end else begin
            o = {~i[WRAP_POS], wrapped[IW-1:0]};
        end
    end

endmodule

// File: rtl/iuq_rn_ptr_track.sv
// Release/allocation pointer tracker for the rename free-list ring.
// All outputs are registered and reflect the inputs of the previous cycle.
module iuq_rn_ptr_track
    import iuq_rn_ptr_track_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic            nclk,
    input  logic            rst,
    input  logic [0:1]      alloc_cnt,
    input  logic [0:1]      unalloc_cnt,
    input  logic [0:1]      rel_cnt,
    input  logic            flush,
    output logic [0:SIZE-1] head,
    output logic [0:SIZE-1] tail,
    output logic [0:SIZE-1] occ,
    output logic [0:SIZE-1] free,
    output logic            empty,
    output logic            full,
    output logic            alloc_ok,
    output logic            err
);

    localparam int IW = SIZE - 1;
    localparam logic [SIZE-1:0] DEPTH_S = DEPTH[SIZE-1:0];

    logic [1:0]      rel_eff, alloc_eff, unalloc_eff;
    logic            rel_ill, alloc_ill, unalloc_ill;
    logic [SIZE-1:0] occ_after_rel;
    logic [0:SIZE-1] tail_next, head_next, head_dec;
    logic [SIZE-1:0] occ_next, free_next;
    logic            err_next;

    function automatic logic [0:SIZE-1] ptr_inc(input logic [0:SIZE-1] p, input logic [1:0] n);
        logic [SIZE-1:0] sum;
        sum = {1'b0, p[IDX_LSB:SIZE-1]} + SIZE'(n);
        if (sum >= DEPTH_S) ptr_inc = {~p[WRAP_POS], IW'(sum - DEPTH_S)};
        else                ptr_inc = {p[WRAP_POS], IW'(sum)};
    endfunction

    function automatic logic [SIZE-1:0] ptr_occ(input logic [0:SIZE-1] h, input logic [0:SIZE-1] t);
        ptr_occ = {1'b0, h[IDX_LSB:SIZE-1]}
                + ((h[WRAP_POS] ^ t[WRAP_POS]) ? DEPTH_S : '0)
                - {1'b0, t[IDX_LSB:SIZE-1]};
    endfunction

    iuq_rn_map_dec #(.SIZE(SIZE), .DEPTH(DEPTH)) u_head_dec (
        .dec (unalloc_eff),
        .i   (head),
        .o   (head_dec)
    );

    // Next tail/head and the protocol-error conditions, all judged against registered occ/free.
    always_comb begin
        rel_ill     = step_cnt_t'(rel_cnt) == STEP_ILLEGAL;
        alloc_ill   = step_cnt_t'(alloc_cnt) == STEP_ILLEGAL;
        unalloc_ill = step_cnt_t'(unalloc_cnt) == STEP_ILLEGAL;
        rel_eff     = rel_ill ? 2'd0 : rel_cnt;
        alloc_eff   = alloc_ill ? 2'd0 : alloc_cnt;
        unalloc_eff = unalloc_ill ? 2'd0 : unalloc_cnt;
        err_next    = err | rel_ill;
        head_next   = head;

        if (SIZE'(rel_eff) > occ) begin
            err_next      = 1'b1;
            tail_next     = head;
            occ_after_rel = '0;
        end else begin
            tail_next     = ptr_inc(tail, rel_eff);
            occ_after_rel = occ - SIZE'(rel_eff);
        end

        if (flush) begin
            head_next = tail_next;
        end else begin
            if (alloc_ill || unalloc_ill) err_next = 1'b1;
            if (unalloc_eff != 2'd0) begin
                if (alloc_eff != 2'd0) err_next = 1'b1;
                if (SIZE'(unalloc_eff) > occ_after_rel) begin
                    err_next  = 1'b1;
                    head_next = tail_next;
                end else begin
                    head_next = head_dec;
                end
            end else if (SIZE'(alloc_eff) > free) begin
                err_next = 1'b1;
            end else begin
                head_next = ptr_inc(head, alloc_eff);
            end
        end

        occ_next  = ptr_occ(head_next, tail_next);
        free_next = DEPTH_S - occ_next;
    end

    // Register pointers and derived status flags.
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            free     <= DEPTH_S;
            empty    <= 1'b1;
            full     <= 1'b0;
            alloc_ok <= 1'b1;
            err      <= 1'b0;
        end else begin
            head     <= head_next;
            tail     <= tail_next;
            occ      <= occ_next;
            free     <= free_next;
            empty    <= occ_next == '0;
            full     <= occ_next == DEPTH_S;
            alloc_ok <= free_next >= SIZE'(2);
            err      <= err_next;
        end
    end

endmodule

// File: tb/tb_iuq_rn_ptr_track.sv
// Self-checking bench for iuq_rn_ptr_track: hand-computed vector table, plan sequences
// with constant checks, and a position-counter reference model feeding a scoreboard.
module tb_iuq_rn_ptr_track;

    localparam int SIZE  = 7;
    localparam int DEPTH = 40;

    logic            nclk = 1'b0;
    logic            rst;
    logic [0:1]      alloc_cnt, unalloc_cnt, rel_cnt;
    logic            flush;
    logic [0:SIZE-1] head, tail, occ, free;
    logic            empty, full, alloc_ok, err;

    iuq_rn_ptr_track #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .nclk        (nclk),
        .rst         (rst),
        .alloc_cnt   (alloc_cnt),
        .unalloc_cnt (unalloc_cnt),
        .rel_cnt     (rel_cnt),
        .flush       (flush),
        .head        (head),
        .tail        (tail),
        .occ         (occ),
        .free        (free),
        .empty       (empty),
        .full        (full),
        .alloc_ok    (alloc_ok),
        .err         (err)
    );

    always #5 nclk = ~nclk;

    typedef struct {
        int head, tail, occ, free;
        bit empty, full, alloc_ok, err;
    } exp_t;

    typedef struct {
        int a, u, r;
        bit f;
        int eh, et, eo;
        bit ee;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: absolute positions modulo 2*DEPTH.
    int hpos, tpos;
    bit merr;

    function automatic int enc(input int pos);
        return (pos >= DEPTH ? 64 : 0) + pos % DEPTH;
    endfunction

    function automatic exp_t mk_exp(input int h, input int t, input int o, input bit e);
        exp_t x;
        x.head = h; x.tail = t; x.occ = o; x.free = DEPTH - o;
        x.empty = (o == 0); x.full = (o == DEPTH); x.alloc_ok = (DEPTH - o) >= 2; x.err = e;
        return x;
    endfunction

    function automatic exp_t model_exp();
        int o;
        o = (hpos - tpos + 2 * DEPTH) % (2 * DEPTH);
        return mk_exp(enc(hpos), enc(tpos), o, merr);
    endfunction

    task automatic model_step(input int a, input int u, input int r, input bit f);
        int o, fr, ntpos, nhpos, rem;
        o  = (hpos - tpos + 2 * DEPTH) % (2 * DEPTH);
        fr = DEPTH - o;
        if (r == 3) begin merr = 1; r = 0; end
        if (r > o) begin merr = 1; ntpos = hpos; end
        else ntpos = (tpos + r) % (2 * DEPTH);
        nhpos = hpos;
        if (f) nhpos = ntpos;
        else begin
            if (a == 3) begin merr = 1; a = 0; end
            if (u == 3) begin merr = 1; u = 0; end
            if (u != 0) begin
                if (a != 0) merr = 1;
                rem = (o > r) ? o - r : 0;
                if (u > rem) begin merr = 1; nhpos = ntpos; end
                else nhpos = (hpos - u + 2 * DEPTH) % (2 * DEPTH);
            end else if (a > fr) merr = 1;
            else nhpos = (hpos + a) % (2 * DEPTH);
        end
        hpos = nhpos;
        tpos = ntpos;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("head", int'(head), e.head);
        chk("tail", int'(tail), e.tail);
        chk("occ", int'(occ), e.occ);
        chk("free", int'(free), e.free);
        chk("empty", int'(empty), int'(e.empty));
        chk("full", int'(full), int'(e.full));
        chk("alloc_ok", int'(alloc_ok), int'(e.alloc_ok));
        chk("err", int'(err), int'(e.err));
    endtask

    task automatic drive(input int a, input int u, input int r, input bit f);
        alloc_cnt   = 2'(a);
        unalloc_cnt = 2'(u);
        rel_cnt     = 2'(r);
        flush       = f;
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            n_cmp--;
            e = sb.pop_front();
            check_out(e);
        end
    endtask

    // One clock with model-generated expectation.
    task automatic step(input int a, input int u, input int r, input bit f);
        drive(a, u, r, f);
        model_step(a, u, r, f);
        sb.push_back(model_exp());
        @(posedge nclk);
        #1;
        pop_check();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst = 1'b1;
        #3;
        sb.delete();
        hpos = 0; tpos = 0; merr = 0;
        check_out(mk_exp(0, 0, 0, 0));
        @(negedge nclk);
        rst = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // inputs: a, u, r, f; expected head, tail, occ, err (hand computed, all wrap 0)
        tbl[0] = '{a:2, u:0, r:0, f:0, eh:2, et:0, eo:2, ee:0};
        tbl[1] = '{a:2, u:0, r:1, f:0, eh:4, et:1, eo:3, ee:0};
        tbl[2] = '{a:0, u:1, r:0, f:0, eh:3, et:1, eo:2, ee:0};
        tbl[3] = '{a:1, u:0, r:2, f:0, eh:4, et:3, eo:1, ee:0};
        tbl[4] = '{a:2, u:0, r:1, f:1, eh:4, et:4, eo:0, ee:0};
        tbl[5] = '{a:2, u:0, r:0, f:0, eh:6, et:4, eo:2, ee:0};
        tbl[6] = '{a:1, u:1, r:0, f:0, eh:5, et:4, eo:1, ee:1};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        hpos = 0; tpos = 0; merr = 0;
        #12;
        rst = 1'b0;

        // Plan 1: idle after reset.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // Hand-computed vector table.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].a, tbl[i].u, tbl[i].r, tbl[i].f);
            model_step(tbl[i].a, tbl[i].u, tbl[i].r, tbl[i].f);
            sb.push_back(mk_exp(tbl[i].eh, tbl[i].et, tbl[i].eo, tbl[i].ee));
            @(posedge nclk);
            #1;
            pop_check();
        end

        // Plan 2: fill to full, alloc at free==1, alloc at full, release+alloc at full.
        do_reset();
        for (int i = 0; i < 19; i++) step(2, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("p2_free1_alloc_ok", int'(alloc_ok), 0);
        step(1, 0, 0, 0);
        chk("p2_full_head", int'(head), 'h40);
        chk("p2_full_occ", int'(occ), 40);
        chk("p2_full_flag", int'(full), 1);
        chk("p2_full_err", int'(err), 0);
        step(1, 0, 0, 0);
        chk("p2_over_err", int'(err), 1);
        chk("p2_over_head", int'(head), 'h40);
        step(1, 0, 1, 0);
        chk("p2_relalloc_tail", int'(tail), 1);
        chk("p2_relalloc_head", int'(head), 'h40);

        // Plan 3: release 2 across the index wrap.
        do_reset();
        for (int i = 0; i < 20; i++) step(2, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 2, 0);
        step(0, 0, 1, 0);
        step(2, 0, 0, 0);
        step(2, 0, 0, 0);
        chk("p3_pre_tail", int'(tail), 'h27);
        chk("p3_pre_occ", int'(occ), 5);
        step(0, 0, 2, 0);
        chk("p3_tail", int'(tail), 'h41);
        chk("p3_occ", int'(occ), 3);

        // Plan 4: unalloc 1 from head index 0.
        do_reset();
        for (int i = 0; i < 20; i++) step(2, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 2, 0);
        chk("p4_pre_tail", int'(tail), 'h22);
        chk("p4_pre_occ", int'(occ), 6);
        step(0, 1, 0, 0);
        chk("p4_head", int'(head), 'h27);
        chk("p4_occ", int'(occ), 5);
        chk("p4_err", int'(err), 0);

        // Plan 5: flush with release and alloc.
        step(2, 0, 0, 0);
        step(2, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("p5_pre_occ", int'(occ), 10);
        step(2, 0, 2, 1);
        chk("p5_tail", int'(tail), 'h24);
        chk("p5_head", int'(head), 'h24);
        chk("p5_empty", int'(empty), 1);
        chk("p5_err", int'(err), 0);

        // Plan 6: over-release clamps tail to head, then async reset mid-cycle.
        step(1, 0, 0, 0);
        step(0, 0, 2, 0);
        chk("p6_err", int'(err), 1);
        chk("p6_tail", int'(tail), int'(head));
        chk("p6_tail_abs", int'(tail), 'h25);
        chk("p6_occ", int'(occ), 0);
        step(2, 0, 0, 0);
        drive(2, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        hpos = 0; tpos = 0; merr = 0;
        check_out(mk_exp(0, 0, 0, 0));
        @(negedge nclk);
        rst = 1'b0;

        // Random traffic checked against the model.
        for (int i = 0; i < 80; i++) begin
            step(int'($urandom_range(0, 2)), (i % 7 == 3) ? int'($urandom_range(0, 2)) : 0,
                 int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
